// File: rtl/pll_reset_seq.sv
// PLL lock to system reset sequencer: synchronizes pll_locked, waits for a stable
// settle window before releasing sys_rst_n, and re-asserts it on filtered lock loss.
module pll_reset_seq #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned GLITCH_FILTER = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic [7:0] relock_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(GLITCH_FILTER - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   lost;

  assign lock_s = sync[SYNC_STAGES-1];
  assign pll_ok = lock_s;

  // One counter serves as settle timer in SETTLE and as unlock filter in RUN;
  // it is cleared on every state change so each use starts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (lock_s) begin
          cnt_nxt = '0;
        end else if (cnt == FILTER_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          lost      = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
    // Software restart overrides everything, including a same-cycle lock-loss count.
    if (sw_rst) begin
      state_nxt = WAIT_LOCK;
      cnt_nxt   = '0;
      lost      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      state      <= WAIT_LOCK;
      cnt        <= '0;
      sys_rst_n  <= 1'b0;
      relock_cnt <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], pll_locked};
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_rst_n <= (state_nxt == RUN);
      if (lost && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: a table of held-input segments with expected
// outputs per edge, plus hand sequences for async reset and relock_cnt saturation.
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst;
  logic       sys_rst_n;
  logic       pll_ok;
  logic [7:0] relock_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic        pl;
    logic        sw;
    int unsigned reps;
    logic        rst;
    logic        ok;
    logic [7:0]  rc;
  } vec_t;

  vec_t vecs[$];

  pll_reset_seq #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(16),
    .GLITCH_FILTER(4),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .sw_rst    (sw_rst),
    .sys_rst_n (sys_rst_n),
    .pll_ok    (pll_ok),
    .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic pl, input logic sw);
    pll_locked = pl;
    sw_rst     = sw;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic pl, input logic sw, input int unsigned reps,
                              input logic rst, input logic ok, input logic [7:0] rc);
    vecs.push_back('{pl, sw, reps, rst, ok, rc});
  endfunction

  initial begin
    int unsigned exp_rc;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    sw_rst     = 1'b0;

    // power-up, no lock
    add(0, 0, 50, 0, 0, 8'd0);
    // lock acquire: ok at edge 2, release at edge 19
    add(1, 0,  1, 0, 0, 8'd0);
    add(1, 0, 17, 0, 1, 8'd0);
    add(1, 0,  5, 1, 1, 8'd0);
    // 3-cycle unlock glitch in RUN is filtered
    add(0, 0,  1, 1, 1, 8'd0);
    add(0, 0,  2, 1, 0, 8'd0);
    add(1, 0,  1, 1, 0, 8'd0);
    add(1, 0,  5, 1, 1, 8'd0);
    // sustained unlock: reset falls at edge 6
    add(0, 0,  1, 1, 1, 8'd0);
    add(0, 0,  4, 1, 0, 8'd0);
    add(0, 0,  4, 0, 0, 8'd1);
    // relock: release 19 edges later
    add(1, 0,  1, 0, 0, 8'd1);
    add(1, 0, 17, 0, 1, 8'd1);
    add(1, 0,  3, 1, 1, 8'd1);
    // sw_rst pulse in RUN
    add(1, 1,  1, 0, 1, 8'd1);
    add(1, 0, 16, 0, 1, 8'd1);
    add(1, 0,  3, 1, 1, 8'd1);
    // lock lost mid-settle, settle restarts
    add(1, 1,  1, 0, 1, 8'd1);
    add(1, 0, 10, 0, 1, 8'd1);
    add(0, 0,  1, 0, 1, 8'd1);
    add(0, 0,  2, 0, 0, 8'd1);
    add(1, 0,  1, 0, 0, 8'd1);
    add(1, 0, 17, 0, 1, 8'd1);
    add(1, 0,  2, 1, 1, 8'd1);
    // sw_rst on the same edge as the lock-loss trigger
    add(0, 0,  1, 1, 1, 8'd1);
    add(0, 0,  4, 1, 0, 8'd1);
    add(0, 1,  1, 0, 0, 8'd1);
    add(0, 0,  3, 0, 0, 8'd1);
    add(1, 0,  1, 0, 0, 8'd1);
    add(1, 0, 17, 0, 1, 8'd1);
    add(1, 0,  2, 1, 1, 8'd1);

    #22;
    check("reset_sys_rst_n", 0, {7'b0, sys_rst_n}, 8'd0);
    check("reset_pll_ok", 0, {7'b0, pll_ok}, 8'd0);
    check("reset_relock_cnt", 0, relock_cnt, 8'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int unsigned r = 0; r < vecs[i].reps; r++) begin
        step(vecs[i].pl, vecs[i].sw);
        check("vec_sys_rst_n", i, {7'b0, sys_rst_n}, {7'b0, vecs[i].rst});
        check("vec_pll_ok", i, {7'b0, pll_ok}, {7'b0, vecs[i].ok});
        check("vec_relock_cnt", i, relock_cnt, vecs[i].rc);
      end
    end

    // async reset at settle count 8
    step(1, 1);
    check("async_pre_sw", 0, {7'b0, sys_rst_n}, 8'd0);
    repeat (9) step(1, 0);
    check("async_pre_settle", 0, {7'b0, sys_rst_n}, 8'd0);
    #3 rst_n = 1'b0;
    #1;
    check("async_sys_rst_n", 0, {7'b0, sys_rst_n}, 8'd0);
    check("async_pll_ok", 0, {7'b0, pll_ok}, 8'd0);
    check("async_relock_cnt", 0, relock_cnt, 8'd0);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0);
      check("async_rel_sys_rst_n", k, {7'b0, sys_rst_n}, (k >= 19) ? 8'd1 : 8'd0);
      check("async_rel_pll_ok", k, {7'b0, pll_ok}, (k >= 2) ? 8'd1 : 8'd0);
    end

    // saturation of relock_cnt
    exp_rc = 0;
    for (int ev = 0; ev < 260; ev++) begin
      repeat (5) step(0, 0);
      check("sat_filter_hold", ev, {7'b0, sys_rst_n}, 8'd1);
      step(0, 0);
      if (exp_rc < 255) exp_rc++;
      check("sat_loss_rst", ev, {7'b0, sys_rst_n}, 8'd0);
      check("sat_relock_cnt", ev, relock_cnt, 8'(exp_rc));
      repeat (18) step(1, 0);
      step(1, 0);
      check("sat_relock_rst", ev, {7'b0, sys_rst_n}, 8'd1);
    end
    check("sat_final", 0, relock_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
